ifu_static_bp: RTL

Instruction fetch unit with static branch prediction. It sits directly upstream of the pre-decoder. It fetches one instruction at a time over a req/gnt/rvalid instruction bus, drives the returned word to the pre-decoder, and uses the pre-decoder's jal/bxx/imm outputs to pick the next fetch PC. Fetched entries are buffered in a small FIFO toward ID, and the buffer is flushed on an EX redirect.

---
 rtl/ifu_static_bp_if.sv | 40 ++++
 rtl/ifu_static_bp.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/ifu_static_bp_if.sv
// Fetch unit boundary: instruction bus, pre-decoder, EX redirect and ID hand-off.
// master = fetch unit side, slave = surrounding pipeline / memory side.
interface ifu_static_bp_if;
    logic        ibus_req_o;
    logic [31:0] ibus_addr_o;
    logic        ibus_gnt_i;
    logic        ibus_rvalid_i;
    logic [31:0] ibus_rdata_i;
    logic [31:0] pd_inst_o;
    logic        pd_jal_i;
    logic        pd_jalr_i;
    logic        pd_bxx_i;
    logic [31:0] pd_imm_i;
    logic        ex_redirect_i;
    logic [31:0] ex_redirect_addr_i;
    logic        id_ready_i;
    logic        if_valid_o;
    logic [31:0] if_inst_o;
    logic [31:0] if_pc_o;
    logic        if_pred_taken_o;
    logic [31:0] if_pred_pc_o;

    modport master (
        output ibus_req_o, ibus_addr_o, pd_inst_o,
        output if_valid_o, if_inst_o, if_pc_o,
        output if_pred_taken_o, if_pred_pc_o,
        input  ibus_gnt_i, ibus_rvalid_i, ibus_rdata_i,
        input  pd_jal_i, pd_jalr_i, pd_bxx_i, pd_imm_i,
        input  ex_redirect_i, ex_redirect_addr_i, id_ready_i
    );

    modport slave (
        input  ibus_req_o, ibus_addr_o, pd_inst_o,
        input  if_valid_o, if_inst_o, if_pc_o,
        input  if_pred_taken_o, if_pred_pc_o,
        output ibus_gnt_i, ibus_rvalid_i, ibus_rdata_i,
        output pd_jal_i, pd_jalr_i, pd_bxx_i, pd_imm_i,
        output ex_redirect_i, ex_redirect_addr_i, id_ready_i
    );
endinterface

// File: rtl/ifu_static_bp.sv
// Single-outstanding fetch unit with BTFN static prediction
// and a small fetch buffer toward ID, flushed on EX redirect.
module ifu_static_bp #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input logic             clk,
    input logic             rst,
    ifu_static_bp_if.master bus
);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);
    localparam logic [AW:0] ONE_C   = (AW+1)'(1);

    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_e;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic        taken;
        logic [31:0] pred;
    } entry_t;

    state_e        state_q, state_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   addr_q, addr_d;
    logic          kill_q, kill_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic [AW:0]   cnt_after;
    entry_t        mem_q [FIFO_DEPTH];
    entry_t        head;
    logic          valid, pop, push, flush, taken;
    logic [31:0]   target;

    assign valid     = (cnt_q != '0);
    assign flush     = bus.ex_redirect_i;
    assign pop       = valid & bus.id_ready_i;
    assign cnt_after = cnt_q - (pop ? ONE_C : '0);

    // JALR is never predicted taken, even if bxx were also flagged
    assign taken  = bus.pd_jal_i
                  | (bus.pd_bxx_i & bus.pd_imm_i[31] & ~bus.pd_jalr_i);
    assign target = taken ? fetch_pc_q + bus.pd_imm_i
                          : fetch_pc_q + 32'd4;

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        kill_d     = kill_q;
        addr_d     = addr_q;
        push       = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (flush || cnt_after < DEPTH_C)
                    state_d = REQ;
            end
            REQ: begin
                if (bus.ibus_gnt_i)
                    state_d = WAIT;
            end
            WAIT: begin
                if (bus.ibus_rvalid_i) begin
                    if (kill_q || flush) begin
                        kill_d  = 1'b0;
                        state_d = REQ;
                    end else begin
                        push       = 1'b1;
                        fetch_pc_d = target;
                        state_d    = (cnt_after + ONE_C < DEPTH_C)
                                   ? REQ : IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (flush) begin
            fetch_pc_d = bus.ex_redirect_addr_i;
            if (state_q == REQ
                || (state_q == WAIT && !bus.ibus_rvalid_i))
                kill_d = 1'b1;
        end
        // request address is latched on entry so it holds through REQ
        if (state_d == REQ && state_q != REQ)
            addr_d = fetch_pc_d;
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (push)
                wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop)
                rd_ptr_d = rd_ptr_q + AW'(1);
            cnt_d = cnt_after + (push ? ONE_C : '0);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            fetch_pc_q <= RESET_PC;
            addr_q     <= RESET_PC;
            kill_q     <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            addr_q     <= addr_d;
            kill_q     <= kill_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cnt_q      <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem_q[wr_ptr_q] <= '{inst:  bus.ibus_rdata_i,
                                 pc:    fetch_pc_q,
                                 taken: taken,
                                 pred:  target};
    end

    assign head = mem_q[rd_ptr_q];

    assign bus.ibus_req_o      = (state_q == REQ);
    assign bus.ibus_addr_o     = addr_q;
    assign bus.pd_inst_o       = bus.ibus_rdata_i;
    assign bus.if_valid_o      = valid;
    assign bus.if_inst_o       = valid ? head.inst : 32'h0000_0013;
    assign bus.if_pc_o         = valid ? head.pc : 32'h0;
    assign bus.if_pred_taken_o = valid & head.taken;
    assign bus.if_pred_pc_o    = valid ? head.pred : 32'h0;
endmodule
